// File: rtl/gate_bist_pkg.sv
// rtl/gate_bist_pkg.sv - shared types, rsp bit map, golden responses and MISR polynomial for gate_bist
package gate_bist_pkg;

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   // Bit positions of the gate outputs on rsp
   localparam int RSP_NOT  = 0;
   localparam int RSP_AND  = 1;
   localparam int RSP_OR   = 2;
   localparam int RSP_NAND = 3;
   localparam int RSP_NOR  = 4;
   localparam int RSP_XOR  = 5;
   localparam int RSP_XNOR = 6;

   // Golden responses per vector index {a,b}; "not" is the inverse of a
   localparam logic [6:0] EXP_V0 = 7'((1 << RSP_NOT) | (1 << RSP_NAND) | (1 << RSP_NOR) | (1 << RSP_XNOR));
   localparam logic [6:0] EXP_V1 = 7'((1 << RSP_NOT) | (1 << RSP_OR) | (1 << RSP_NAND) | (1 << RSP_XOR));
   localparam logic [6:0] EXP_V2 = 7'((1 << RSP_OR) | (1 << RSP_NAND) | (1 << RSP_XOR));
   localparam logic [6:0] EXP_V3 = 7'((1 << RSP_AND) | (1 << RSP_OR) | (1 << RSP_XNOR));

   // x^8+x^4+x^3+x^2+1
   localparam logic [7:0] MISR_POLY = 8'h1D;

   function automatic logic [6:0] expected(input logic [1:0] idx);
      case (idx)
         2'd0:    return EXP_V0;
         2'd1:    return EXP_V1;
         2'd2:    return EXP_V2;
         default: return EXP_V3;
      endcase
   endfunction

endpackage

// File: rtl/gate_bist_misr.sv
// rtl/gate_bist_misr.sv - 8-bit response signature register, built only with GATE_BIST_MISR_EN
`ifdef GATE_BIST_MISR_EN
module gate_bist_misr
   import gate_bist_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       seed,
   input  logic       en,
   input  logic [6:0] data,
   output logic [7:0] sig
);

   // Seed on run start, otherwise shift-and-fold one response per enabled cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig <= 8'h00;
      end else if (seed) begin
         sig <= 8'hFF;
      end else if (en) begin
         sig <= {sig[6:0], 1'b0} ^ (sig[7] ? MISR_POLY : 8'h00) ^ {1'b0, data};
      end
   end

endmodule
`endif

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - self-test sweep of the two-input gate block; GATE_BIST_MISR_EN adds a response signature
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int PASSES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       a,
   output logic       b,
   input  logic [6:0] rsp,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] fail_mask,
   output logic [7:0] err_cnt,
   output logic [1:0] vec_idx
`ifdef GATE_BIST_MISR_EN
   ,
   output logic [7:0] signature
`endif
);

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
   localparam logic [3:0]  PASS_LAST   = 4'(PASSES - 1);

   state_t      state, nxt_state;
   logic [15:0] settle_cnt, nxt_settle;
   logic [3:0]  pass_cnt, nxt_pass_cnt;
   logic        nxt_a, nxt_b, nxt_busy, nxt_done, nxt_pass;
   logic [6:0]  nxt_fail, mismatch;
   logic [7:0]  nxt_err;
   logic [1:0]  nxt_vec;

   // Next state and next value of every registered output
   always_comb begin
      nxt_state    = state;
      nxt_settle   = settle_cnt;
      nxt_pass_cnt = pass_cnt;
      nxt_a        = a;
      nxt_b        = b;
      nxt_busy     = busy;
      nxt_done     = 1'b0;
      nxt_pass     = pass;
      nxt_fail     = fail_mask;
      nxt_err      = err_cnt;
      nxt_vec      = vec_idx;
      mismatch     = rsp ^ expected(vec_idx);

      if (state != IDLE && abort) begin
         // Partial results stay visible; the in-flight sample is dropped
         nxt_state  = IDLE;
         nxt_settle = '0;
         nxt_a      = 1'b0;
         nxt_b      = 1'b0;
         nxt_busy   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  nxt_state    = APPLY;
                  nxt_settle   = '0;
                  nxt_pass_cnt = '0;
                  nxt_vec      = 2'd0;
                  nxt_a        = 1'b0;
                  nxt_b        = 1'b0;
                  nxt_busy     = 1'b1;
                  nxt_pass     = 1'b0;
                  nxt_fail     = '0;
                  nxt_err      = '0;
               end
            end
            APPLY: begin
               if (settle_cnt == SETTLE_LAST) begin
                  nxt_settle = '0;
                  nxt_state  = SAMPLE;
               end else begin
                  nxt_settle = settle_cnt + 16'd1;
               end
            end
            SAMPLE: begin
               nxt_fail = fail_mask | mismatch;
               if (mismatch != 7'd0 && err_cnt != 8'hFF) begin
                  nxt_err = err_cnt + 8'd1;
               end
               if (vec_idx != 2'd3) begin
                  nxt_vec   = vec_idx + 2'd1;
                  nxt_a     = nxt_vec[1];
                  nxt_b     = nxt_vec[0];
                  nxt_state = APPLY;
               end else if (pass_cnt != PASS_LAST) begin
                  nxt_vec      = 2'd0;
                  nxt_a        = 1'b0;
                  nxt_b        = 1'b0;
                  nxt_pass_cnt = pass_cnt + 4'd1;
                  nxt_state    = APPLY;
               end else begin
                  nxt_a     = 1'b0;
                  nxt_b     = 1'b0;
                  nxt_busy  = 1'b0;
                  nxt_state = DONE;
               end
            end
            default: begin
               // err_cnt already includes the final sample here
               nxt_done  = 1'b1;
               nxt_pass  = (err_cnt == 8'd0);
               nxt_state = IDLE;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         settle_cnt <= '0;
         pass_cnt   <= '0;
         a          <= 1'b0;
         b          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_mask  <= '0;
         err_cnt    <= '0;
         vec_idx    <= '0;
      end else begin
         state      <= nxt_state;
         settle_cnt <= nxt_settle;
         pass_cnt   <= nxt_pass_cnt;
         a          <= nxt_a;
         b          <= nxt_b;
         busy       <= nxt_busy;
         done       <= nxt_done;
         pass       <= nxt_pass;
         fail_mask  <= nxt_fail;
         err_cnt    <= nxt_err;
         vec_idx    <= nxt_vec;
      end
   end

`ifdef GATE_BIST_MISR_EN
   gate_bist_misr u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (state == IDLE && start && !abort),
      .en    (state == SAMPLE && !abort),
      .data  (rsp),
      .sig   (signature)
   );
`endif

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - randomized and directed check of gate_bist against a timeline model; GATE_BIST_MISR_EN adds signature checks
module tb_gate_bist;

   localparam int SETTLE = 2;
   localparam int PASSES = 1;
   localparam int V      = SETTLE + 1;
   localparam int RUN    = 4 * PASSES * V;

   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, start3 = 1'b0;
   logic       a, b, busy, done, pass;
   logic [6:0] rsp, fail_mask;
   logic [7:0] err_cnt;
   logic [1:0] vec_idx;
   logic       a3, b3, busy3, done3, pass3;
   logic [6:0] fm3;
   logic [7:0] ec3;
   logic [1:0] vi3;
`ifdef GATE_BIST_MISR_EN
   logic [7:0] signature, sig3, sig_good;
`endif

   logic [6:0] rsp_and = 7'h7F, rsp_or = 7'h00, flip_bits = 7'h00;
   logic [1:0] flip_vec = 2'd0;
   int         total = 0, bad = 0;
   bit         chk_en = 1'b0;

   always #5 clk = ~clk;

   // Ideal gate block, bit order {xnor,xor,nor,nand,or,and,not}
   function automatic logic [6:0] gates(input logic ga, input logic gb);
      return {~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb, ~ga};
   endfunction

   // Gate block with the currently configured faults
   function automatic logic [6:0] rsp_of(input logic [1:0] j);
      logic [6:0] r;
      r = (gates(j[1], j[0]) & rsp_and) | rsp_or;
      if (j == flip_vec) r = r ^ flip_bits;
      return r;
   endfunction

   assign rsp = rsp_of({a, b});

   gate_bist #(.SETTLE(SETTLE), .PASSES(PASSES)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b), .rsp(rsp),
      .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask), .err_cnt(err_cnt),
      .vec_idx(vec_idx)
`ifdef GATE_BIST_MISR_EN
      , .signature(signature)
`endif
   );

   gate_bist #(.SETTLE(2), .PASSES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0), .a(a3), .b(b3), .rsp(7'h00),
      .busy(busy3), .done(done3), .pass(pass3), .fail_mask(fm3), .err_cnt(ec3),
      .vec_idx(vi3)
`ifdef GATE_BIST_MISR_EN
      , .signature(sig3)
`endif
   );

   // Model: k counts edges since start acceptance; vector g is sampled on edge (g+1)*V
   bit         m_active = 1'b0, m_pass = 1'b0, m_done = 1'b0;
   int         k = 0, m_err = 0, g = 0;
   logic [6:0] m_fail = '0, m_r, m_mm;
   logic [1:0] m_vec = '0, m_j;
   logic [7:0] m_sig = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_active = 0; k = 0; m_fail = '0; m_err = 0; m_pass = 0; m_done = 0; m_vec = '0; m_sig = '0;
      end else if (!m_active) begin
         m_done = 0;
         if (start && !abort) begin
            m_active = 1; k = 0; m_fail = '0; m_err = 0; m_pass = 0; m_vec = '0; m_sig = 8'hFF;
         end
      end else if (abort) begin
         m_active = 0;
      end else begin
         k++;
         if (k % V == 0 && k <= RUN) begin
            g    = k / V - 1;
            m_j  = 2'(g % 4);
            m_r  = rsp_of(m_j);
            m_mm = m_r ^ gates(m_j[1], m_j[0]);
            m_fail = m_fail | m_mm;
            if (m_mm != 0 && m_err < 255) m_err++;
            m_sig = {m_sig[6:0], 1'b0} ^ (m_sig[7] ? 8'h1D : 8'h00) ^ {1'b0, m_r};
            if (k < RUN) m_vec = m_j + 2'd1;
         end
         if (k == RUN + 1) begin
            m_done = 1; m_pass = (m_err == 0); m_active = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      bit eb;
      if (chk_en) begin
         eb = m_active && (k < RUN);
         chk("busy", busy, eb);
         chk("a", a, eb ? m_vec[1] : 1'b0);
         chk("b", b, eb ? m_vec[0] : 1'b0);
         chk("done", done, m_done);
         chk("pass", pass, m_pass);
         chk("vec_idx", vec_idx, m_vec);
         chk("fail_mask", fail_mask, m_fail);
         chk("err_cnt", err_cnt, m_err);
`ifdef GATE_BIST_MISR_EN
         chk("signature", signature, m_sig);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run_check(input string nm, input int lat, input logic ep,
                            input logic [6:0] em, input logic [7:0] ee);
      int cyc;
      start = 1; tick(); start = 0;
      cyc = 0;
      while (!done && cyc < 200) begin tick(); cyc++; end
      chk({nm, "_lat"}, cyc, lat);
      chk({nm, "_pass"}, pass, ep);
      chk({nm, "_mask"}, fail_mask, em);
      chk({nm, "_err"}, err_cnt, ee);
      tick();
   endtask

   initial begin
      int cyc, seen;
      repeat (3) tick();
      chk_en = 1;
      chk("rst_busy", busy, 0);
      chk("rst_ab", {a, b}, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_mask", fail_mask, 0);
      chk("rst_vec", vec_idx, 0);
      rst_n = 1; tick();

      run_check("good", 13, 1, 7'h00, 8'd0);
`ifdef GATE_BIST_MISR_EN
      chk("good_sig", signature, 8'h13);
`endif
      rsp_and = 7'h00;
      run_check("zero", 13, 0, 7'h7F, 8'd4);
      rsp_and = 7'h7D;
      run_check("and_sa0", 13, 0, 7'h02, 8'd1);
      rsp_and = 7'h7F;

      // Abort in the second vector's APPLY, with a stray start mid-run
      start = 1; tick(); start = 0;
      tick(); start = 1; tick(); start = 0; tick();
      abort = 1; tick(); abort = 0;
      chk("abort_busy", busy, 0);
      chk("abort_ab", {a, b}, 0);
      chk("abort_vec", vec_idx, 1);
      seen = 0;
      repeat (20) begin tick(); if (done) seen++; end
      chk("abort_nodone", seen, 0);
      chk("abort_pass", pass, 0);
      run_check("after_abort", 13, 1, 7'h00, 8'd0);

      // Reset while in SAMPLE with a fault present
      rsp_and = 7'h00;
      start = 1; tick(); start = 0;
      tick(); tick();
      rst_n = 0; tick();
      chk("rstmid_all", {a, b, busy, done, pass, fail_mask, err_cnt, vec_idx}, 0);
      rst_n = 1; rsp_and = 7'h7F; tick();
      run_check("after_rst", 13, 1, 7'h00, 8'd0);

`ifdef GATE_BIST_MISR_EN
      sig_good = m_sig;
      flip_vec = 2'd2; flip_bits = 7'h10;
      run_check("flip", 13, 0, 7'h10, 8'd1);
      total++;
      if (signature === sig_good) begin
         bad++;
         $display("FAIL flip_sig: got %0h, must differ from %0h", signature, sig_good);
      end
      flip_bits = 7'h00;
`endif

      // Three-pass instance with rsp tied low
      start3 = 1; tick(); start3 = 0;
      cyc = 0;
      while (!done3 && cyc < 300) begin tick(); cyc++; end
      chk("p3_lat", cyc, 37);
      chk("p3_err", ec3, 12);
      chk("p3_mask", fm3, 7'h7F);
      chk("p3_pass", pass3, 0);

      // Random starts, aborts, resets and fault patterns
      repeat (1500) begin
         start = ($urandom % 6 == 0);
         abort = ($urandom % 30 == 0);
         rst_n = ($urandom % 250 != 0);
         if ($urandom % 12 == 0) begin
            case ($urandom % 4)
               0: begin rsp_and = 7'h7F; rsp_or = 7'h00; flip_bits = 7'h00; end
               1: rsp_and = 7'($urandom);
               2: rsp_or = 7'($urandom) & 7'($urandom);
               default: begin flip_vec = 2'($urandom); flip_bits = 7'(1 << ($urandom % 7)); end
            endcase
         end
         tick();
      end
      start = 0; abort = 0; rst_n = 1;
      repeat (20) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
